// File: rtl/traffic_input_conditioner.sv
// Synchronises/debounces walk button and vehicle sensor, makes the 1 s tick, holds walk requests.
// Latency: raw edge to debounced level DB_CYCLES+2 clk; no backpressure (walk_ack is the only handshake).
module traffic_input_conditioner #(
  parameter int TICK_DIV         = 100000000,
  parameter int DB_CYCLES        = 1000000,
  parameter int SENSOR_MIN_TICKS = 2,
  parameter int LOCKOUT_TICKS    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic walk_button_in,
  input  logic sensor_in,
  input  logic walk_ack,
  output logic tick,
  output logic walk_req,
  output logic walk_press,
  output logic sensor_q
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SNW = (SENSOR_MIN_TICKS > 0) ? $clog2(SENSOR_MIN_TICKS + 1) : 1;
  localparam int LKW = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;

  typedef enum logic [1:0] {W_IDLE, W_PENDING, W_LOCKOUT} walk_state_e;

  // bit 0 = walk button, bit 1 = vehicle sensor
  logic [1:0]     sync1_q, sync2_q, db_q, db_d;
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];
  logic [TKW-1:0] tick_cnt_q, tick_cnt_d;
  logic           tick_q, tick_d;
  logic           btn_prev_q, press_q, press_now;
  logic [1:0]     ready_q;
  logic           armed_q, armed_d;
  logic [SNW-1:0] sen_cnt_q, sen_cnt_d;
  logic           sen_qual_q, sen_qual_d;
  walk_state_e    state_q, state_d;
  logic [LKW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DBW'(DB_CYCLES - 1)) db_d[i] = ~db_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    tick_d     = (tick_cnt_q == TKW'(TICK_DIV - 1));
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + 1'b1;
  end

  // A button already held when reset releases must be seen low before it may request.
  assign armed_d   = armed_q | (ready_q[1] & ~sync2_q[0]);
  assign press_now = db_q[0] & ~btn_prev_q & armed_q;

  always_comb begin
    sen_cnt_d = sen_cnt_q;
    if (!db_q[1]) sen_cnt_d = '0;
    else if (tick_q && (sen_cnt_q < SNW'(SENSOR_MIN_TICKS))) sen_cnt_d = sen_cnt_q + 1'b1;
    sen_qual_d = db_q[1] && (sen_cnt_q >= SNW'(SENSOR_MIN_TICKS));
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      W_IDLE: if (press_now) state_d = W_PENDING;
      W_PENDING: begin
        if (walk_ack) begin
          if (LOCKOUT_TICKS == 0) begin
            state_d = W_IDLE;
          end else begin
            state_d    = W_LOCKOUT;
            lock_cnt_d = LKW'(LOCKOUT_TICKS);
          end
        end
      end
      W_LOCKOUT: begin
        if (tick_q) begin
          lock_cnt_d = lock_cnt_q - 1'b1;
          if (lock_cnt_q == LKW'(1)) state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      btn_prev_q  <= 1'b0;
      press_q     <= 1'b0;
      ready_q     <= '0;
      armed_q     <= 1'b0;
      sen_cnt_q   <= '0;
      sen_qual_q  <= 1'b0;
      state_q     <= W_IDLE;
      lock_cnt_q  <= '0;
    end else begin
      sync1_q     <= {sensor_in, walk_button_in};
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      btn_prev_q  <= db_q[0];
      press_q     <= press_now;
      ready_q     <= {ready_q[0], 1'b1};
      armed_q     <= armed_d;
      sen_cnt_q   <= sen_cnt_d;
      sen_qual_q  <= sen_qual_d;
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  assign tick       = tick_q;
  assign walk_press = press_q;
  assign sensor_q   = sen_qual_q;
  assign walk_req   = (state_q == W_PENDING);
endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed + random bench for traffic_input_conditioner; expectations come from a history-based
// model of the debounce/tick/sensor rules and an event-level walk-request state machine.
module tb_traffic_input_conditioner;
  localparam int TD = 4, DB = 3, SMIN = 2, LK = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic walk_button_in = 1'b0, sensor_in = 1'b0, walk_ack = 1'b0;
  logic tick, walk_req, walk_press, sensor_q;
  logic tick0, walk_req0, walk_press0, sensor_q0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  traffic_input_conditioner #(.TICK_DIV(TD), .DB_CYCLES(DB), .SENSOR_MIN_TICKS(SMIN),
                              .LOCKOUT_TICKS(LK)) dut (
    .clk(clk), .rst(rst), .walk_button_in(walk_button_in), .sensor_in(sensor_in),
    .walk_ack(walk_ack), .tick(tick), .walk_req(walk_req), .walk_press(walk_press),
    .sensor_q(sensor_q));

  traffic_input_conditioner #(.TICK_DIV(TD), .DB_CYCLES(DB), .SENSOR_MIN_TICKS(SMIN),
                              .LOCKOUT_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .walk_button_in(walk_button_in), .sensor_in(sensor_in),
    .walk_ack(walk_ack), .tick(tick0), .walk_req(walk_req0), .walk_press(walk_press0),
    .sensor_q(sensor_q0));

  // History since the last reset release, indexed by edge number (edge 1 = first after release).
  bit rb [0:2047];
  bit rs [0:2047];
  bit ra [0:2047];
  bit dbb [0:2047];
  bit dbs [0:2047];
  bit tk [0:2047];
  bit pr [0:2047];
  bit sq [0:2047];
  int t = 0;
  int wst [2];
  int wrem [2];
  int lkcfg [2] = '{LK, 0};

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %b expected %b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit sample(input bit is_sens, input int j);
    if (j < 1) return 1'b0;
    return is_sens ? rs[j] : rb[j];
  endfunction

  // Level flips only once DB consecutive synchronised samples disagree with it.
  function automatic bit settle(input bit is_sens, input bit cur, input int e);
    for (int j = e - 1 - DB; j <= e - 2; j++)
      if (sample(is_sens, j) == cur) return cur;
    return !cur;
  endfunction

  function automatic void model_reset();
    t = 0; dbb[0] = 0; dbs[0] = 0; tk[0] = 0; pr[0] = 0; sq[0] = 0;
    wst = '{0, 0}; wrem = '{0, 0};
  endfunction

  function automatic void model_edge();
    bit armed, tick_now;
    int cnt, r;
    dbb[t] = settle(1'b0, dbb[t-1], t);
    dbs[t] = settle(1'b1, dbs[t-1], t);
    tk[t]  = (t % TD == 0);
    armed = 0;
    for (int j = 1; j <= t - 3; j++) if (!rb[j]) armed = 1;
    pr[t] = 0;
    if (t >= 2) pr[t] = dbb[t-1] && !dbb[t-2] && armed;
    cnt = 0;
    if (dbs[t-1]) begin
      r = t - 1;
      while (dbs[r-1]) r--;
      for (int w = r; w <= t - 2; w++) cnt += int'(tk[w]);
    end
    sq[t] = dbs[t-1] && (cnt >= SMIN);
    tick_now = (t >= 2) ? tk[t-1] : 1'b0;
    for (int d = 0; d < 2; d++) begin
      case (wst[d])
        0: if (pr[t]) wst[d] = 1;
        1: if (ra[t]) begin
             wrem[d] = lkcfg[d];
             wst[d]  = (lkcfg[d] == 0) ? 0 : 2;
           end
        default: if (tick_now) begin
             wrem[d]--;
             if (wrem[d] == 0) wst[d] = 0;
           end
      endcase
    end
  endfunction

  task automatic step(input bit b, input bit s, input bit a);
    walk_button_in = b; sensor_in = s; walk_ack = a;
    @(posedge clk);
    t++; rb[t] = b; rs[t] = s; ra[t] = a;
    model_edge();
    #1;
    chk("tick", tick, tk[t]);
    chk("walk_press", walk_press, pr[t]);
    chk("sensor_q", sensor_q, sq[t]);
    chk("walk_req", walk_req, wst[0] == 1);
    chk("walk_req_lk0", walk_req0, wst[1] == 1);
    chk("walk_press_lk0", walk_press0, pr[t]);
    walk_ack = 1'b0;
  endtask

  task automatic run(input int n, input bit b, input bit s);
    for (int i = 0; i < n; i++) step(b, s, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk("rst_async_tick", tick, 1'b0);
    chk("rst_async_walk_req", walk_req, 1'b0);
    chk("rst_async_sensor_q", sensor_q, 1'b0);
    chk("rst_async_walk_press", walk_press, 1'b0);
    chk("rst_async_walk_req_lk0", walk_req0, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    chk("rst_held_outputs", tick | walk_req | sensor_q | walk_press, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit pat [11] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    bit b, s;
    int nticks;

    do_reset(3);
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      nticks += int'(tick);
    end
    chk_int("tick_count_20", nticks, 5);
    chk("tick_edge20", tick, 1'b1);
    do_reset(2);
    run(3, 1'b0, 1'b0);
    chk("tick_edge3_after_rst", tick, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("tick_edge4_after_rst", tick, 1'b1);

    // Bouncing button, then a clean hold
    do_reset(2);
    run(8, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(pat[i], 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("req_edge24", walk_req, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("press_edge25", walk_press, 1'b1);
    chk("req_edge25", walk_req, 1'b1);

    // Second press while pending is absorbed
    run(2, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("press_edge39", walk_press, 1'b1);
    chk("req_edge39", walk_req, 1'b1);

    // Ack, then a press one cycle later lands in lockout (or in IDLE with no lockout)
    run(6, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("req_after_ack", walk_req, 1'b0);
    chk("req_after_ack_lk0", walk_req0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("press_in_lockout", walk_press, 1'b1);
    chk("req_dropped_in_lockout", walk_req, 1'b0);
    chk("req_lk0_press_after_ack", walk_req0, 1'b1);
    run(4, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("req_after_lockout", walk_req, 1'b1);

    // Press coincident with ack
    run(6, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("press_with_ack", walk_press, 1'b1);
    chk("req_press_with_ack", walk_req, 1'b0);
    chk("req_press_with_ack_lk0", walk_req0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("req_after_coincident", walk_req, 1'b0);

    // Sensor qualification and release
    run(3, 1'b1, 1'b0);
    run(6, 1'b1, 1'b1);
    run(3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("sensor_edge93", sensor_q, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("sensor_edge94", sensor_q, 1'b1);
    run(5, 1'b0, 1'b1);
    run(4, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sensor_edge104", sensor_q, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("sensor_edge105", sensor_q, 1'b0);
    run(2, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sensor_short_high", sensor_q, 1'b0);
    run(4, 1'b0, 1'b0);

    // Reset with request and sensor active, button held through release
    step(1'b0, 1'b1, 1'b0);
    run(14, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("req_before_rst", walk_req, 1'b1);
    chk("sensor_before_rst", sensor_q, 1'b1);
    do_reset(3);
    run(20, 1'b1, 1'b0);
    chk("req_held_through_rst", walk_req, 1'b0);
    run(6, 1'b0, 1'b0);
    run(5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("press_after_repress", walk_press, 1'b1);
    chk("req_after_repress", walk_req, 1'b1);

    // Random traffic against the model
    do_reset(2);
    b = 0; s = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) b = !b;
      if ($urandom_range(5) == 0) s = !s;
      step(b, s, $urandom_range(9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
